branch_predict_cmp: RTL



---
 rtl/branch_predict_cmp_if.sv | 37 +++
 rtl/branch_predict_cmp.sv | 124 ++++++++++++
 2 files changed

// File: rtl/branch_predict_cmp_if.sv
//------------------------------------------------------------------------------
// Module      : branch_predict_cmp_if
// Description : ID/IF-side signal bundle of the branch resolution unit.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface branch_predict_cmp_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int CNT_W  = 32
);
    logic [PC_W-1:0]   if_pc;
    logic              pred_taken;
    logic              judge;
    logic              stall;
    logic [PC_W-1:0]   id_pc;
    logic              id_pred;
    logic [2:0]        cmp_op;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [1:0]        npc_op;
    logic [CNT_W-1:0]  br_count;
    logic [CNT_W-1:0]  miss_count;

    modport master (
        output if_pc, judge, stall, id_pc, id_pred, cmp_op, rs_data, rt_data,
        input  pred_taken, npc_op, br_count, miss_count
    );

    modport slave (
        input  if_pc, judge, stall, id_pc, id_pred, cmp_op, rs_data, rt_data,
        output pred_taken, npc_op, br_count, miss_count
    );
endinterface

`default_nettype wire

// File: rtl/branch_predict_cmp.sv
//------------------------------------------------------------------------------
// Module      : branch_predict_cmp
// Description : ID-stage branch resolution, NPC redirect select, 2-bit BHT
//               training and resolved/mispredict performance counters.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module branch_predict_cmp #(
    parameter int DATA_W    = 32,
    parameter int PC_W      = 32,
    parameter int BHT_DEPTH = 16,
    parameter int CNT_W     = 32
) (
    input  logic                clk,
    input  logic                reset,
    branch_predict_cmp_if.slave bus
);

    localparam int         IDX_W       = $clog2(BHT_DEPTH);
    localparam logic [1:0] c_WEAK_NT   = 2'b01;
    localparam logic [1:0] c_SAT_HI    = 2'b11;
    localparam logic [1:0] c_SAT_LO    = 2'b00;
    localparam logic [1:0] c_NPC_NONE  = 2'b00;
    localparam logic [1:0] c_NPC_TGT   = 2'b01;
    localparam logic [1:0] c_NPC_FALL  = 2'b10;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [1:0]       bht_q [BHT_DEPTH];
    logic [1:0]       bht_d [BHT_DEPTH];
    logic [CNT_W-1:0] br_count_q;
    logic [CNT_W-1:0] br_count_d;
    logic [CNT_W-1:0] miss_count_q;
    logic [CNT_W-1:0] miss_count_d;

    logic [IDX_W-1:0] w_if_idx;
    logic [IDX_W-1:0] w_id_idx;
    logic             w_update;
    logic             w_cond;
    logic             w_rs_neg;
    logic             w_rs_zero;
    logic [1:0]       w_npc_raw;
    logic             w_unused_pc_bits;

    assign w_if_idx = bus.if_pc[IDX_W+1:2];
    assign w_id_idx = bus.id_pc[IDX_W+1:2];

    // Word-offset and upper PC bits do not take part in the table index.
    assign w_unused_pc_bits = ^{bus.if_pc[1:0], bus.if_pc[PC_W-1:IDX_W+2],
                                bus.id_pc[1:0], bus.id_pc[PC_W-1:IDX_W+2]};

    // Flops ignore D while reset is low, so reset only needs to gate npc_op.
    assign w_update  = bus.judge & ~bus.stall;
    assign w_rs_neg  = bus.rs_data[DATA_W-1];
    assign w_rs_zero = (bus.rs_data == '0);

    always_comb begin
        w_cond = 1'b0;
        case (bus.cmp_op)
            3'b000:  w_cond = (bus.rs_data == bus.rt_data);
            3'b001:  w_cond = (bus.rs_data != bus.rt_data);
            3'b010:  w_cond = w_rs_neg | w_rs_zero;
            3'b011:  w_cond = ~w_rs_neg & ~w_rs_zero;
            3'b100:  w_cond = w_rs_neg;
            3'b101:  w_cond = ~w_rs_neg;
            default: w_cond = 1'b0;
        endcase
    end

    always_comb begin
        w_npc_raw = c_NPC_NONE;
        if (w_update) begin
            if (w_cond && !bus.id_pred) begin
                w_npc_raw = c_NPC_TGT;
            end else if (!w_cond && bus.id_pred) begin
                w_npc_raw = c_NPC_FALL;
            end
        end
    end

    always_comb begin
        bht_d        = bht_q;
        br_count_d   = br_count_q;
        miss_count_d = miss_count_q;
        if (w_update) begin
            if (w_cond) begin
                if (bht_q[w_id_idx] != c_SAT_HI) begin
                    bht_d[w_id_idx] = bht_q[w_id_idx] + 2'b01;
                end
            end else if (bht_q[w_id_idx] != c_SAT_LO) begin
                bht_d[w_id_idx] = bht_q[w_id_idx] - 2'b01;
            end
            if (!(&br_count_q)) begin
                br_count_d = br_count_q + c_CNT_ONE;
            end
            if ((w_npc_raw != c_NPC_NONE) && !(&miss_count_q)) begin
                miss_count_d = miss_count_q + c_CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= c_WEAK_NT;
            end
            br_count_q   <= '0;
            miss_count_q <= '0;
        end else begin
            bht_q        <= bht_d;
            br_count_q   <= br_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    // Lookup reads the registered table: a same-cycle update is not bypassed.
    assign bus.pred_taken = bht_q[w_if_idx][1];
    assign bus.npc_op     = reset ? w_npc_raw : c_NPC_NONE;
    assign bus.br_count   = br_count_q;
    assign bus.miss_count = miss_count_q;

endmodule

`default_nettype wire
